// File: rtl/keypad_scan_ctrl.sv
// ROWS x COLS matrix keypad scanner: row synchroniser, press/release debounce, valid/ready code output.
// Define KEYPAD_AUTOREPEAT_EN to re-present a held key every REPEAT_CYCLES cycles.
module keypad_scan_ctrl #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SETTLE_CYCLES   = 1,
  parameter int REPEAT_CYCLES   = 1000,
  localparam int CW             = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  output logic [CW-1:0]   code,
  output logic            valid,
  input  logic            ready,
  output logic            overflow
);
  localparam int RIW       = $clog2(ROWS);
  localparam int CIW       = $clog2(COLS);
  localparam int DW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW        = $clog2(SETTLE_CYCLES + 2);
  localparam int SAMPLE_AT = SETTLE_CYCLES + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_HOLD} state_t;

  state_t          r_state, w_state_next;
  logic [ROWS-1:0] r_sync1, r_row_s;
  logic [DW-1:0]   r_deb_cnt, w_deb_cnt_next;
  logic [SW-1:0]   r_set_cnt, w_set_cnt_next;
  logic [CIW-1:0]  r_col, w_col_next;
  logic [RIW-1:0]  r_row, w_row_next;
  logic [CW-1:0]   r_code, w_code_next;
  logic            r_valid, w_valid_next;
  logic            r_ovf, w_ovf_next;

  logic            w_any;
  logic            w_deb_done;
  logic            w_set_done;
  logic            w_last_col;
  logic [RIW-1:0]  w_low_row;
  logic [COLS-1:0] w_col_onehot;
  logic [CW-1:0]   w_new_code;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0]   r_rep_cnt, w_rep_cnt_next;
  logic            w_rep_done;
  assign w_rep_done = (32'(r_rep_cnt) + 1) >= REPEAT_CYCLES;
`endif

  assign w_any        = |r_row_s;
  assign w_deb_done   = (32'(r_deb_cnt) + 1) == DEBOUNCE_CYCLES;
  assign w_set_done   = (r_set_cnt == SW'(SAMPLE_AT));
  assign w_last_col   = (r_col == CIW'(COLS - 1));
  assign w_col_onehot = COLS'(1) << r_col;
  assign w_new_code   = CW'(32'(r_row) * COLS + 32'(r_col));

  assign code     = r_code;
  assign valid    = r_valid;
  assign overflow = r_ovf;

  // Lowest asserted row wins when several rows answer the same column.
  always_comb begin
    w_low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (r_row_s[i]) w_low_row = RIW'(i);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_deb_cnt_next = r_deb_cnt;
    w_set_cnt_next = r_set_cnt;
    w_col_next     = r_col;
    w_row_next     = r_row;
    w_code_next    = r_code;
    w_valid_next   = r_valid;
    w_ovf_next     = r_ovf;
`ifdef KEYPAD_AUTOREPEAT_EN
    w_rep_cnt_next = r_rep_cnt;
`endif
    col_out        = '1;

    if (r_valid && ready) w_valid_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          if (w_deb_done) begin
            w_state_next   = S_SCAN;
            w_deb_cnt_next = '0;
            w_col_next     = '0;
            w_set_cnt_next = '0;
          end else begin
            w_deb_cnt_next = r_deb_cnt + DW'(1);
          end
        end else begin
          w_deb_cnt_next = '0;
        end
      end

      // Settle window covers the column change propagating through the row synchroniser.
      S_SCAN: begin
        col_out = w_col_onehot;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_rep_cnt_next = '0;
`endif
        if (!w_set_done) begin
          w_set_cnt_next = r_set_cnt + SW'(1);
        end else if (w_any) begin
          w_row_next   = w_low_row;
          w_state_next = S_EMIT;
        end else if (w_last_col) begin
          w_state_next = S_IDLE;
        end else begin
          w_col_next     = r_col + CIW'(1);
          w_set_cnt_next = '0;
        end
      end

      S_EMIT: begin
        col_out        = w_col_onehot;
        w_state_next   = S_HOLD;
        w_deb_cnt_next = '0;
        if (!r_valid || ready) begin
          w_code_next  = w_new_code;
          w_valid_next = 1'b1;
        end else begin
          w_ovf_next = 1'b1;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        // The emit cycle counts toward the repeat interval so repeats land exactly REPEAT_CYCLES apart.
        w_rep_cnt_next = w_rep_done ? '0 : r_rep_cnt + RW'(1);
`endif
      end

      S_HOLD: begin
        if (!w_any) begin
          if (w_deb_done) begin
            w_state_next   = S_IDLE;
            w_deb_cnt_next = '0;
          end else begin
            w_deb_cnt_next = r_deb_cnt + DW'(1);
          end
        end else begin
          w_deb_cnt_next = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          if (w_rep_done) begin
            w_rep_cnt_next = '0;
            w_state_next   = S_EMIT;
          end else begin
            w_rep_cnt_next = r_rep_cnt + RW'(1);
          end
`endif
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= '0;
      r_row_s   <= '0;
      r_state   <= S_IDLE;
      r_deb_cnt <= '0;
      r_set_cnt <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep_cnt <= '0;
`endif
    end else begin
      r_sync1   <= row_in;
      r_row_s   <= r_sync1;
      r_state   <= w_state_next;
      r_deb_cnt <= w_deb_cnt_next;
      r_set_cnt <= w_set_cnt_next;
      r_col     <= w_col_next;
      r_row     <= w_row_next;
      r_code    <= w_code_next;
      r_valid   <= w_valid_next;
      r_ovf     <= w_ovf_next;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep_cnt <= w_rep_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: keypad matrix model, handshake monitor, table + random tests.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DEB  = 8;
  localparam int SET  = 1;
  localparam int REP  = 50;
  localparam int CW   = $clog2(ROWS*COLS);
  localparam int ALL1 = (1 << COLS) - 1;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HOLD_T = 45;
`else
  localparam int HOLD_T = 100;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [ROWS-1:0]      row_in;
  logic [COLS-1:0]      col_out;
  logic [CW-1:0]        code;
  logic                 valid;
  logic                 ready;
  logic                 overflow;

  logic [ROWS*COLS-1:0] keys = '0;
  logic [ROWS-1:0]      glitch = '0;
  logic                 ready_fixed = 1'b1;
  logic                 rnd_en = 1'b0;
  logic                 rnd_bit = 1'b0;
  int                   total = 0;
  int                   bad = 0;
  int                   cyc = 0;
  int                   acc_code[$];
  int                   acc_cyc[$];

  typedef struct {
    logic [ROWS*COLS-1:0] mask;
    int                   exp_code;
  } vec_t;
  vec_t tbl[7];

  keypad_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .DEBOUNCE_CYCLES(DEB),
    .SETTLE_CYCLES(SET), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out),
    .code(code), .valid(valid), .ready(ready), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  assign ready = rnd_en ? rnd_bit : ready_fixed;

  // Passive keypad: a pressed key shorts its row to its column while that column is driven.
  always_comb begin
    row_in = glitch;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS + c] && col_out[c]) row_in[r] = 1'b1;
  end

  always @(negedge clk) begin
    #1;
    if (!reset && valid && ready) begin
      acc_code.push_back(int'(code));
      acc_cyc.push_back(cyc);
      $display("handshake cyc=%0d code=%0d", cyc, code);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic int model_code(input logic [ROWS*COLS-1:0] m);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (m[r*COLS + c]) return r*COLS + c;
    return -1;
  endfunction

  function automatic int model_latency(input int kc);
    return 2 + DEB + ((kc % COLS) + 1) * (SET + 2) + 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [ROWS*COLS-1:0] m, output int lat);
    keys = m;
    lat  = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (valid) break;
    end
    check("valid_seen", int'(valid), 1);
  endtask

  task automatic clear_acc();
    acc_code.delete();
    acc_cyc.delete();
  endtask

  function automatic int first_acc();
    return (acc_code.size() > 0) ? acc_code[0] : -1;
  endfunction

  initial begin
    int lat, errs, seen, exp_c, found;
    logic [ROWS*COLS-1:0] m;

    tbl[0] = '{16'h0200, 9};   // (2,1)
    tbl[1] = '{16'h0001, 0};   // (0,0)
    tbl[2] = '{16'h8000, 15};  // (3,3)
    tbl[3] = '{16'h0080, 7};   // (1,3)
    tbl[4] = '{16'h0140, 8};   // (2,0)+(1,2)
    tbl[5] = '{16'h2002, 1};   // (3,1)+(0,1)
    tbl[6] = '{16'h0448, 6};   // (1,2)+(2,2)+(0,3)

    reset = 1'b1;
    tick(3);
    check("rst_col_out", int'(col_out), ALL1);
    check("rst_code", int'(code), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    tick(5);

    // Table: one code per press, latency, column idle level while held.
    for (int t = 0; t < 7; t++) begin
      clear_acc();
      ready_fixed = 1'b1;
      press(tbl[t].mask, lat);
      check_range($sformatf("tbl%0d_latency", t), lat,
                  model_latency(tbl[t].exp_code) - 1, model_latency(tbl[t].exp_code) + 1);
      check($sformatf("tbl%0d_code", t), int'(code), tbl[t].exp_code);
      tick(20);
      check($sformatf("tbl%0d_hold_col_out", t), int'(col_out), ALL1);
      tick(HOLD_T - 20);
      keys = '0;
      tick(30);
      check($sformatf("tbl%0d_count", t), acc_code.size(), 1);
      check($sformatf("tbl%0d_acc_code", t), first_acc(), tbl[t].exp_code);
      check($sformatf("tbl%0d_idle_valid", t), int'(valid), 0);
    end

    // Backpressure: code held stable while ready stays low, drops one cycle after acceptance.
    clear_acc();
    ready_fixed = 1'b0;
    press(16'h0080, lat);
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 30) keys = '0;
      tick(1);
      if (!(valid && code == CW'(7))) errs++;
    end
    check("bp_stable_errs", errs, 0);
    ready_fixed = 1'b1;
    tick(1);
    check("bp_valid_drop", int'(valid), 0);
    check("bp_overflow", int'(overflow), 0);
    check("bp_acc_code", first_acc(), 7);

    // Overflow: second code arrives while first is still pending.
    clear_acc();
    ready_fixed = 1'b0;
    press(16'h0001, lat);
    keys = '0;
    tick(20);
    keys = 16'h8000;
    tick(40);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_code_kept", int'(code), 0);
    check("ovf_valid", int'(valid), 1);
    keys = '0;
    tick(20);
    ready_fixed = 1'b1;
    tick(1);
    check("ovf_valid_drop", int'(valid), 0);
    tick(40);
    check("ovf_count", acc_code.size(), 1);
    check("ovf_acc_code", first_acc(), 0);
    check("ovf_sticky", int'(overflow), 1);
    reset = 1'b1;
    tick(2);
    check("ovf_cleared_by_reset", int'(overflow), 0);
    reset = 1'b0;
    tick(5);

    // Glitches: short one never reaches scan; one of exactly DEB cycles scans all columns and emits nothing.
    clear_acc();
    glitch = 4'b0100;
    tick(3);
    glitch = '0;
    errs = 0;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (int'(col_out) != ALL1) errs++;
    end
    check("glitch3_no_scan", errs, 0);
    glitch = 4'b0100;
    tick(DEB);
    glitch = '0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (int'(col_out) != ALL1) seen |= int'(col_out);
    end
    check("glitch8_cols_scanned", seen, ALL1);
    check("glitch8_col_out_idle", int'(col_out), ALL1);
    check("glitch8_valid", int'(valid), 0);
    check("glitch8_count", acc_code.size(), 0);

    // Reset mid-scan abandons the scan.
    clear_acc();
    keys = 16'h8000;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (col_out == 4'b0100) begin
        found = 1;
        break;
      end
    end
    check("midscan_reached", found, 1);
    reset = 1'b1;
    keys = '0;
    tick(1);
    check("midscan_rst_col_out", int'(col_out), ALL1);
    check("midscan_rst_valid", int'(valid), 0);
    check("midscan_rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    tick(40);
    check("midscan_no_code", acc_code.size(), 0);

    // Extra key pressed while one is held is ignored.
    clear_acc();
    press(16'h0020, lat);
    keys = 16'h0021;
    tick(30);
    keys = '0;
    tick(30);
    check("held_extra_count", acc_code.size(), 1);
    check("held_extra_code", first_acc(), 5);

    // Randomised presses against the reference model with random ready.
    rnd_en = 1'b1;
    for (int t = 0; t < 16; t++) begin
      clear_acc();
      m = '0;
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) m[$urandom_range(0, ROWS*COLS-1)] = 1'b1;
      exp_c = model_code(m);
      press(m, lat);
      check_range($sformatf("rnd%0d_latency", t), lat, model_latency(exp_c) - 1, model_latency(exp_c) + 1);
      check($sformatf("rnd%0d_code", t), int'(code), exp_c);
      tick(int'($urandom_range(20, 40)));
      keys = '0;
      tick(60);
      check($sformatf("rnd%0d_count", t), acc_code.size(), 1);
      check($sformatf("rnd%0d_acc_code", t), first_acc(), exp_c);
    end
    rnd_en = 1'b0;
    ready_fixed = 1'b1;
    tick(5);
    check("rnd_overflow", int'(overflow), 0);

`ifdef KEYPAD_AUTOREPEAT_EN
    clear_acc();
    press(16'h4000, lat);
    tick(230);
    keys = '0;
    tick(40);
    check("rep_count", acc_code.size(), 5);
    for (int i = 1; i < 5; i++) begin
      if (i < acc_cyc.size()) begin
        check($sformatf("rep_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], REP);
        check($sformatf("rep_code%0d", i), acc_code[i], 14);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
